alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning the data width of all operands and the result (legal range 8..64).
REQ-002 The block SHALL have localparam SHW = clog2(DWIDTH), meaning the shift-amount width.
REQ-003 Port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port Resetn, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of Clk.
REQ-005 Port En, input, 1 bit: pipeline advance; 0 = stall.
REQ-006 Port In_Valid, input, 1 bit: the operands and opcode are valid this cycle.
REQ-007 Ports ALU_In0, ALU_In1 and ALU_In2, input, DWIDTH each: the operands.
REQ-008 Port Opcode, input, 4 bits: the operation select.
REQ-009 Port ALU_Out, output, DWIDTH, registered: the result.
REQ-010 Port Out_Valid, output, 1 bit, registered: ALU_Out carries a valid result.
REQ-011 Port Op_Err, output, 1 bit, registered: the result came from an undefined opcode.

Function
REQ-012 The block SHALL implement the following operations; all arithmetic wraps modulo 2^DWIDTH, and products keep the low DWIDTH bits:
- 0 NOP: 0
- 1 MULADD: In0*In1+In2
- 2 MULSUB: In0*In1-In2
- 3 ADDADD: In0+In1+In2
- 4 ADDSUB: In0+In1-In2
- 5 SUBSUB: In0-In1-In2
- 6 PHI: (In0!=0) ? In1 : In2
- 7 RSFAND: (In0 >> In1[SHW-1:0]) & In2, logical shift
- 8 LSFADD: (In0 << In1[SHW-1:0]) + In2
- 9 ABS: two's-complement |In0|, where the most negative value maps to itself
- 10 GT: signed In0 > In1 ? 1 : 0
- 11 LET: signed In0 <= In1 ? 1 : 0
- 12 ANDAND: In0 & In1 & In2
REQ-013 Opcodes 13-15 SHALL produce ALU_Out=0, with Op_Err=1 travelling alongside the result.
REQ-014 The latency SHALL be fixed at 3 En-qualified cycles for every opcode: a transaction accepted on edge k (En=1) SHALL appear on ALU_Out/Out_Valid/Op_Err after edge k+2 counted in En=1 edges (a 3-stage pipeline whose last stage is the output register).
REQ-015 The pipeline stages SHALL be:
- S1: register operands, opcode and valid
- S2: multiply and first add/sub/shift/compare
- S3: final add/sub/select into the output registers
REQ-016 Every stage SHALL carry its own valid bit and opcode, so that back-to-back transactions with different opcodes issue every cycle at full throughput.
REQ-017 When En=0, all pipeline registers including ALU_Out, Out_Valid and Op_Err SHALL hold their values, and inputs SHALL be ignored.
REQ-018 A transaction with In_Valid=0 SHALL propagate as a bubble: Out_Valid=0, ALU_Out=0 and Op_Err=0 when it reaches the output.
REQ-019 Opcode 0 with In_Valid=1 SHALL give Out_Valid=1 and ALU_Out=0.
REQ-020 Operand changes after acceptance SHALL NOT affect in-flight results.
REQ-021 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-022 When Resetn=0 at a rising edge, all stage registers, valid bits, ALU_Out, Out_Valid and Op_Err SHALL become 0, regardless of En.
REQ-023 A reset applied mid-operation SHALL discard all in-flight transactions; none SHALL emerge after reset release.
REQ-024 The first transaction accepted on the first edge with Resetn=1 SHALL emerge with the normal 3-cycle latency.

Verification
REQ-025 Streaming: DWIDTH=32, back-to-back MULADD(3,4,5), SUBSUB(10,3,2), GT(-1,0), LET(-1,0), one per cycle with En=1 -> outputs 17, 5, 0, 1 on consecutive cycles, with Out_Valid=1 starting 3 cycles after the first.
REQ-026 Boundaries:
- ABS(0x80000000) -> 0x80000000
- MULSUB(0xFFFFFFFF,2,1) -> 0xFFFFFFFD
- RSFAND(0xF0,36,0xFF) -> 0x0F, because the shift amount is 36 mod 32 = 4
- LSFADD(1,31,1) -> 0x80000001
REQ-027 Stall: issue ADDADD(1,2,3), then hold En=0 for 4 cycles after 1 cycle -> the result 6 appears exactly 3 En=1 cycles after issue, and ALU_Out/Out_Valid are stable throughout the stall.
REQ-028 Bubbles and errors: the sequence PHI(0,7,9), idle (In_Valid=0), opcode 14 -> outputs 9 (Out_Valid=1), then Out_Valid=0, then ALU_Out=0 with Out_Valid=1 and Op_Err=1.
REQ-029 Reset mid-flight: issue 3 ANDAND transactions, assert Resetn=0 for 1 cycle after the 2nd issue -> all outputs are 0 the next cycle, and Out_Valid stays 0 for 3 cycles after release with no new issue.
REQ-030 Parametric: DWIDTH=8 with MULADD(16,16,1) -> 0x01, and GT(0x80,0x7F) -> 0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/opcode request and registered result bundle for alu_pipe
interface alu_pipe_if #(parameter int DWIDTH = 32);
  logic              En;
  logic              In_Valid;
  logic [DWIDTH-1:0] ALU_In0;
  logic [DWIDTH-1:0] ALU_In1;
  logic [DWIDTH-1:0] ALU_In2;
  logic [3:0]        Opcode;
  logic [DWIDTH-1:0] ALU_Out;
  logic              Out_Valid;
  logic              Op_Err;
  modport master (output En, In_Valid, ALU_In0, ALU_In1, ALU_In2, Opcode, input ALU_Out, Out_Valid, Op_Err);
  modport slave  (input En, In_Valid, ALU_In0, ALU_In1, ALU_In2, Opcode, output ALU_Out, Out_Valid, Op_Err);
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: three-stage pipelined ALU with stall, bubbles and undefined-opcode flag
module alu_pipe #(parameter int DWIDTH = 32) (
  input logic       Clk,
  input logic       Resetn,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(DWIDTH);
  logic              v1, v2;
  logic [3:0]        op1, op2;
  logic [DWIDTH-1:0] a1, b1, c1, t, t2, c2, f;
  // stage 2 front half: multiply, first add/sub, shift, compare or select
  always_comb begin
    case (op1)
      4'd1, 4'd2: t = a1 * b1;
      4'd3, 4'd4: t = a1 + b1;
      4'd5:       t = a1 - b1;
      4'd6:       t = (a1 != '0) ? b1 : c1;
      4'd7:       t = a1 >> b1[SHW-1:0];
      4'd8:       t = a1 << b1[SHW-1:0];
      4'd9:       t = a1[DWIDTH-1] ? -a1 : a1;
      4'd10:      t = DWIDTH'($signed(a1) > $signed(b1));
      4'd11:      t = DWIDTH'($signed(a1) <= $signed(b1));
      4'd12:      t = a1 & b1;
      default:    t = '0;
    endcase
  end
  // stage 3 combine: final add/sub/and with the carried third operand
  always_comb begin
    case (op2)
      4'd1, 4'd3, 4'd8:          f = t2 + c2;
      4'd2, 4'd4, 4'd5:          f = t2 - c2;
      4'd7, 4'd12:               f = t2 & c2;
      4'd6, 4'd9, 4'd10, 4'd11:  f = t2;
      default:                   f = '0;
    endcase
  end
  // pipeline registers; reset wins over En, En=0 freezes every stage
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      v1 <= 1'b0;
      op1 <= '0;
      a1 <= '0;
      b1 <= '0;
      c1 <= '0;
      v2 <= 1'b0;
      op2 <= '0;
      t2 <= '0;
      c2 <= '0;
      bus.ALU_Out <= '0;
      bus.Out_Valid <= 1'b0;
      bus.Op_Err <= 1'b0;
    end else if (bus.En) begin
      v1 <= bus.In_Valid;
      op1 <= bus.Opcode;
      a1 <= bus.ALU_In0;
      b1 <= bus.ALU_In1;
      c1 <= bus.ALU_In2;
      v2 <= v1;
      op2 <= op1;
      t2 <= t;
      c2 <= c1;
      bus.ALU_Out <= v2 ? f : '0;
      bus.Out_Valid <= v2;
      bus.Op_Err <= v2 && (op2 >= 4'd13);
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe with directed vectors at 32 and 8 bits
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  alu_pipe_if #(.DWIDTH(32)) bus ();
  alu_pipe_if #(.DWIDTH(8))  bus8 ();
  alu_pipe #(.DWIDTH(32)) dut (.Clk(clk), .Resetn(rstn), .bus(bus));
  alu_pipe #(.DWIDTH(8))  dut8 (.Clk(clk), .Resetn(rstn), .bus(bus8));
  typedef struct {logic [31:0] d; logic e; int due;} exp_t;
  exp_t q[$];
  exp_t sb;
  int n_cmp = 0;
  int n_bad = 0;
  int en_edges = 0;
  logic en_q = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask
  task automatic iss(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] r, input logic err);
    bus.In_Valid = 1'b1;
    bus.Opcode = op;
    bus.ALU_In0 = a;
    bus.ALU_In1 = b;
    bus.ALU_In2 = c;
    q.push_back('{r, err, en_edges + 3});
    @(negedge clk);
  endtask
  task automatic idle();
    bus.In_Valid = 1'b0;
    bus.Opcode = 4'd1;
    bus.ALU_In0 = $urandom;
    bus.ALU_In1 = $urandom;
    bus.ALU_In2 = $urandom;
    @(negedge clk);
  endtask
  task automatic t8(input string nm, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] r);
    bus8.In_Valid = 1'b1;
    bus8.Opcode = op;
    bus8.ALU_In0 = a;
    bus8.ALU_In1 = b;
    bus8.ALU_In2 = c;
    @(negedge clk);
    bus8.In_Valid = 1'b0;
    bus8.ALU_In0 = 8'hAA;
    repeat (2) @(negedge clk);
    chk({nm, "_valid"}, bus8.Out_Valid, 1);
    chk(nm, bus8.ALU_Out, r);
  endtask
  always @(posedge clk) begin
    en_q <= bus.En;
    if (bus.En) en_edges <= en_edges + 1;
  end
  always @(negedge clk) begin
    if (en_q && bus.Out_Valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h, expected no valid output", bus.ALU_Out);
      end else begin
        sb = q.pop_front();
        chk("result", bus.ALU_Out, sb.d);
        chk("op_err", bus.Op_Err, sb.e);
        chk("latency", en_edges, sb.due);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    bus.En = 1'b1;
    bus.In_Valid = 1'b1;
    bus.Opcode = 4'd1;
    bus.ALU_In0 = 32'd7;
    bus.ALU_In1 = 32'd7;
    bus.ALU_In2 = 32'd7;
    bus8.En = 1'b1;
    bus8.In_Valid = 1'b0;
    bus8.Opcode = 4'd0;
    bus8.ALU_In0 = '0;
    bus8.ALU_In1 = '0;
    bus8.ALU_In2 = '0;
    repeat (4) @(negedge clk);
    chk("rst_out", bus.ALU_Out, 0);
    chk("rst_valid", bus.Out_Valid, 0);
    chk("rst_err", bus.Op_Err, 0);
    rstn = 1'b1;
    iss(4'd1, 32'd3, 32'd4, 32'd5, 32'd17, 1'b0);
    iss(4'd5, 32'd10, 32'd3, 32'd2, 32'd5, 1'b0);
    iss(4'd10, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 1'b0);
    iss(4'd11, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd1, 1'b0);
    iss(4'd9, 32'h80000000, 32'd0, 32'd0, 32'h80000000, 1'b0);
    iss(4'd2, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFD, 1'b0);
    iss(4'd7, 32'hF0, 32'd36, 32'hFF, 32'h0F, 1'b0);
    iss(4'd8, 32'd1, 32'd31, 32'd1, 32'h80000001, 1'b0);
    iss(4'd0, 32'd9, 32'd9, 32'd9, 32'd0, 1'b0);
    iss(4'd4, 32'd10, 32'd20, 32'd5, 32'd25, 1'b0);
    iss(4'd6, 32'd5, 32'd7, 32'd9, 32'd7, 1'b0);
    iss(4'd12, 32'hFF0F, 32'h0FFF, 32'h00FF, 32'h000F, 1'b0);
    iss(4'd9, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd5, 1'b0);
    iss(4'd3, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1, 1'b0);
    repeat (4) idle();
    iss(4'd12, 32'hF, 32'h3, 32'h7, 32'd3, 1'b0);
    iss(4'd3, 32'd1, 32'd2, 32'd3, 32'd6, 1'b0);
    idle();
    bus.En = 1'b0;
    bus.In_Valid = 1'b1;
    bus.Opcode = 4'd3;
    bus.ALU_In0 = 32'd100;
    repeat (4) begin
      @(negedge clk);
      chk("stall_out", bus.ALU_Out, 3);
      chk("stall_valid", bus.Out_Valid, 1);
    end
    bus.En = 1'b1;
    repeat (4) idle();
    iss(4'd6, 32'd0, 32'd7, 32'd9, 32'd9, 1'b0);
    idle();
    iss(4'd14, 32'd1, 32'd2, 32'd3, 32'd0, 1'b1);
    idle();
    chk("bubble_valid", bus.Out_Valid, 0);
    chk("bubble_out", bus.ALU_Out, 0);
    chk("bubble_err", bus.Op_Err, 0);
    repeat (3) idle();
    iss(4'd12, 32'hFF, 32'h0F, 32'h3C, 32'h0C, 1'b0);
    iss(4'd12, 32'h1, 32'h1, 32'h1, 32'h1, 1'b0);
    rstn = 1'b0;
    q.delete();
    bus.In_Valid = 1'b1;
    bus.Opcode = 4'd12;
    bus.ALU_In0 = 32'hFFFFFFFF;
    @(negedge clk);
    chk("midrst_out", bus.ALU_Out, 0);
    chk("midrst_valid", bus.Out_Valid, 0);
    chk("midrst_err", bus.Op_Err, 0);
    rstn = 1'b1;
    bus.In_Valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", bus.Out_Valid, 0);
    end
    t8("w8_muladd", 4'd1, 8'd16, 8'd16, 8'd1, 8'h01);
    t8("w8_gt", 4'd10, 8'h80, 8'h7F, 8'd0, 8'h00);
    t8("w8_abs", 4'd9, 8'h80, 8'd0, 8'd0, 8'h80);
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
